// File: rtl/pixel_scan_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pixel_scan_generator_if                                   |
// | Brief    : Control and coordinate bundle of the pixel scan generator |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface pixel_scan_generator_if;
    logic        start;
    logic        hold;
    logic        credit_return;
    logic [31:0] screen_x;
    logic [31:0] screen_y;
    logic        coords_valid;
    logic        sof;
    logic        eol;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        credit_err;

    modport master (
        input  start, hold, credit_return,
        output screen_x, screen_y, coords_valid, sof, eol,
               busy, frame_done, frame_count, credit_err
    );

    modport slave (
        output start, hold, credit_return,
        input  screen_x, screen_y, coords_valid, sof, eol,
               busy, frame_done, frame_count, credit_err
    );
endinterface
`default_nettype wire

// File: rtl/pixel_scan_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pixel_scan_generator                                      |
// | Brief    : Credit-limited raster scan source with frame sequencing   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module pixel_scan_generator #(
    parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
    parameter int MAX_IN_FLIGHT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    pixel_scan_generator_if.master        bus
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam int CW = $clog2(MAX_IN_FLIGHT + 1);

    localparam logic [XW-1:0] X_LAST     = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(SCREEN_HEIGHT - 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_IN_FLIGHT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] credits;

    logic issue;
    logic at_max;
    logic ret_ok;
    logic last_px;

    assign issue   = (state == SCAN) && !bus.hold && (credits != '0);
    assign at_max  = (credits == CREDIT_MAX);
    // A return that coincides with an issue is always absorbed, even at MAX.
    assign ret_ok  = bus.credit_return && (!at_max || issue);
    assign last_px = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            x                <= '0;
            y                <= '0;
            credits          <= CREDIT_MAX;
            bus.screen_x     <= '0;
            bus.screen_y     <= '0;
            bus.coords_valid <= 1'b0;
            bus.sof          <= 1'b0;
            bus.eol          <= 1'b0;
            bus.busy         <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.frame_count  <= '0;
            bus.credit_err   <= 1'b0;
        end else begin
            bus.coords_valid <= issue;
            bus.sof          <= issue && (x == '0) && (y == '0);
            bus.eol          <= issue && (x == X_LAST);
            bus.frame_done   <= 1'b0;

            if (issue) begin
                bus.screen_x <= 32'(x);
                bus.screen_y <= 32'(y);
            end

            if (issue && !ret_ok) begin
                credits <= credits - CW'(1);
            end else if (!issue && ret_ok) begin
                credits <= credits + CW'(1);
            end

            if (bus.credit_return && !ret_ok) begin
                bus.credit_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SCAN;
                        bus.busy <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (last_px) begin
                            state <= DRAIN;
                            x     <= '0;
                            y     <= '0;
                        end else if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (at_max) begin
                        state           <= IDLE;
                        bus.busy        <= 1'b0;
                        bus.frame_done  <= 1'b1;
                        bus.frame_count <= bus.frame_count + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/pixel_scan_generator.md
# pixel_scan_generator

Upstream source for the ray generator stage: raster-scans the screen and emits one integer pixel coordinate pair per issue cycle on `screen_x`/`screen_y`/`coords_valid`. The ray pipeline has no backpressure, so the block limits the number of pixels in flight with a credit counter. Downstream returns a credit with `credit_return` when a pixel's result has been consumed. The block also sequences frames (start, drain, done) and marks frame and line boundaries.

## Interface
Parameters:
- `SCREEN_WIDTH`, default `` `SCREEN_WIDTH `` (640): pixels per line; must be ≥ 2.
- `SCREEN_HEIGHT`, default `` `SCREEN_HEIGHT `` (480): lines per frame; must be ≥ 2.
- `MAX_IN_FLIGHT`, default 16: credit pool size; must be ≥ 1.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `start`  in  1  — begin a frame; sampled only in IDLE.
- `hold`  in  1  — stalls issue while high; does not affect credit accounting.
- `credit_return`  in  1  — one credit returned per cycle it is high.
- `screen_x`  out  32 (`fp`)  — pixel column as a raw integer in 0..W-1, not shifted; the consumer applies `FRAC_BITS`.
- `screen_y`  out  32 (`fp`)  — pixel row as a raw integer in 0..H-1.
- `coords_valid`  out  1  — one-cycle qualifier for the coordinate pair.
- `sof`  out  1  — high with the (0,0) pixel only.
- `eol`  out  1  — high with every pixel where x = W-1.
- `busy`  out  1  — high in SCAN and DRAIN.
- `frame_done`  out  1  — one-cycle pulse when a frame fully drains.
- `frame_count`  out  16  — completed frames; wraps 0xFFFF→0.
- `credit_err`  out  1  — sticky; set by a return when credits are already full.

## Operation
- States:
  - IDLE → SCAN when `start` is high. The x/y counters clear on this transition.
  - SCAN → DRAIN on the cycle the last pixel (W-1, H-1) issues.
  - DRAIN → IDLE when credits equal MAX_IN_FLIGHT. `frame_done` is asserted and `frame_count` increments on that edge.
- Issue condition: state = SCAN and `hold` = 0 and credits > 0.
  - On issue: register x/y onto the outputs, assert `coords_valid`, decrement credits.
  - Advance x. At x = W-1, x wraps to 0 and y increments.
- No issue cycle: `coords_valid`, `sof` and `eol` are low. `screen_x`/`screen_y` hold their last values.
- Credits:
  - Counter width is clog2(MAX_IN_FLIGHT+1); reset value is MAX_IN_FLIGHT.
  - Issue and return in the same cycle leave the count unchanged.
  - A return while credits = MAX is ignored (no increment) and sets `credit_err`.
  - Returns are accepted in every state, including IDLE.
- `start` while `busy` is ignored. `start` held high across `frame_done` begins the next frame on the following cycle, because the block is then in IDLE.
- `hold` in DRAIN or IDLE has no effect.
- Reset mid-frame aborts the frame, with no `frame_done`. The downstream pipeline must be reset together with this block.
- Reset values:
  - State IDLE, x = y = 0, credits = MAX.
  - `screen_x` = `screen_y` = 0.
  - `coords_valid`, `sof`, `eol`, `busy`, `frame_done` = 0.
  - `frame_count` = 0, `credit_err` = 0.

## Timing
- All outputs are registered; there is no combinational input→output path.
- `start` high in cycle 0: `busy` is high from cycle 1. With credits available and `hold` low, `sof`+`coords_valid` with (0,0) appear in cycle 2.
- Throughput is one pixel per cycle when credits never reach 0. An unstalled frame spans W·H consecutive `coords_valid` cycles.
- Credit-starved issue:
  - A return in cycle n makes issue possible in cycle n+1, so the first coordinate appears at the outputs in cycle n+2.
  - With credits = 0 and `credit_return` = 1, no issue occurs that cycle; the count becomes 1.
- `hold` asserted in cycle n suppresses the issue that would appear in cycle n+1. Deassertion resumes at the next unissued pixel with no skip or repeat.
- `frame_done` rises in the cycle after credits reach MAX in DRAIN, and `busy` falls in the same cycle. If the last return coincides with the last issue, the block still passes through DRAIN for at least one cycle.

## Test plan
1. W=4, H=3, MAX=16, `credit_return` mirrors `coords_valid` delayed 5 cycles, `start` at cycle 0:
   - 12 consecutive valids from cycle 2, (0,0)…(3,2) in raster order.
   - `sof` only on the first; `eol` on x=3 at cycles 5, 9, 13.
   - `frame_done` after the last return; `frame_count` = 1.
2. MAX=2, no returns: exactly 2 valids, then stall with `busy` = 1. Returning one credit at cycle 20 produces (2,0) in cycle 22.
3. `hold` high for cycles 4–7 mid-line: valids stop and resume with the next coordinate. The total is still 12, with no duplicates.
4. `start` pulsed during SCAN: ignored, `frame_count` unchanged. `start` held high continuously: back-to-back frames separated by one IDLE cycle.
5. `credit_return` while credits = MAX in IDLE: `credit_err` = 1 and stays set; credits remain MAX.
6. `rst` low at pixel (2,1): next cycle all outputs are at reset values. A new `start` begins again at (0,0) with `sof`.
